// File: rtl/run_detector_pkg.sv
// Shared constants for the run detector: piece codes and default geometry.
package run_detector_pkg;

    localparam int PIECE_EMPTY      = 0;
    localparam int PIECE_RED        = 1;
    localparam int PIECE_YELLOW     = 2;

    localparam int WIN_LEN_DEFAULT  = 4;
    localparam int LINE_MAX_DEFAULT = 7;

endpackage

// File: rtl/run_detector_run_tracker.sv
// Tracks the current run of equal non-empty pieces within a line.
// Optional feature macro: RUN_DETECTOR_POS_EN keeps the run_start register
// so the line index of the run's first cell can be reported.
module run_tracker
    import run_detector_pkg::*;
#(
    parameter int PIECE_W = 2,
`ifdef RUN_DETECTOR_POS_EN
    parameter int POS_W   = 3,
`endif
    parameter int WIN_LEN = WIN_LEN_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               accept,
    input  logic [PIECE_W-1:0] piece,
    input  logic               new_line,
`ifdef RUN_DETECTOR_POS_EN
    input  logic [POS_W-1:0]   pos,
    output logic [POS_W-1:0]   run_start_next,
`endif
    output logic [PIECE_W-1:0] run_piece_next,
    output logic               run_full_next
);

    localparam int               LEN_W   = $clog2(WIN_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIN_LEN);

    logic [PIECE_W-1:0] run_piece_reg;
    logic [LEN_W-1:0]   run_len_reg;
    logic [LEN_W-1:0]   run_len_next;
    logic               is_empty;
    logic               extends_run;

    assign is_empty    = (piece == PIECE_W'(PIECE_EMPTY));
    // A run only continues inside the same line with the same non-empty code
    assign extends_run = !is_empty && !new_line && (piece == run_piece_reg);

    // Next run piece/length: empty breaks, equal extends (saturating), other restarts
    always_comb begin
        run_piece_next = run_piece_reg;
        run_len_next   = run_len_reg;
        if (accept) begin
            if (is_empty) begin
                run_piece_next = '0;
                run_len_next   = '0;
            end else if (extends_run) begin
                if (run_len_reg != LEN_MAX) begin
                    run_len_next = run_len_reg + LEN_W'(1);
                end
            end else begin
                run_piece_next = piece;
                run_len_next   = LEN_W'(1);
            end
        end
    end

    assign run_full_next = (run_len_next == LEN_MAX);

    // Run piece/length registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_piece_reg <= '0;
            run_len_reg   <= '0;
        end else begin
            run_piece_reg <= run_piece_next;
            run_len_reg   <= run_len_next;
        end
    end

`ifdef RUN_DETECTOR_POS_EN
    logic [POS_W-1:0] run_start_reg;

    // A restarting non-empty piece marks the start of a new run
    always_comb begin
        run_start_next = run_start_reg;
        if (accept && !is_empty && !extends_run) begin
            run_start_next = pos;
        end
    end

    // Run start register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_start_reg <= '0;
        end else begin
            run_start_reg <= run_start_next;
        end
    end
`endif

endmodule

// File: rtl/run_detector.sv
// Detects WIN_LEN consecutive equal non-empty pieces within a line and
// latches the first win since reset/clear.
// Optional feature macro: RUN_DETECTOR_POS_EN captures the winning run's
// starting line index into win_pos; without it win_pos is constant 0.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int  PIECE_W  = 2,
    parameter int  WIN_LEN  = WIN_LEN_DEFAULT,
    parameter int  LINE_MAX = LINE_MAX_DEFAULT,
    localparam int POS_W    = $clog2(LINE_MAX)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [PIECE_W-1:0] in_piece,
    input  logic               in_last,
    output logic [PIECE_W-1:0] out,
    output logic               win_latched,
    output logic [PIECE_W-1:0] win_piece,
    output logic [POS_W-1:0]   win_pos
);

    logic [POS_W-1:0]   pos_reg;
    logic [POS_W-1:0]   pos_next;
    logic               new_line_reg;
    logic               new_line_next;
    logic [PIECE_W-1:0] out_reg;
    logic [PIECE_W-1:0] out_next;
    logic               win_latched_reg;
    logic [PIECE_W-1:0] win_piece_reg;
    logic [PIECE_W-1:0] run_piece_next;
    logic               run_full_next;
    logic               new_win;
`ifdef RUN_DETECTOR_POS_EN
    logic [POS_W-1:0]   run_start_next;
    logic [POS_W-1:0]   win_pos_reg;
`endif

    run_tracker #(
        .PIECE_W        (PIECE_W),
`ifdef RUN_DETECTOR_POS_EN
        .POS_W          (POS_W),
`endif
        .WIN_LEN        (WIN_LEN)
    ) u_tracker (
        .clock          (clock),
        .reset          (reset),
        .accept         (in_valid),
        .piece          (in_piece),
        .new_line       (new_line_reg),
`ifdef RUN_DETECTOR_POS_EN
        .pos            (pos_reg),
        .run_start_next (run_start_next),
`endif
        .run_piece_next (run_piece_next),
        .run_full_next  (run_full_next)
    );

    // Line index advances per accepted piece, wrapping at line end or LINE_MAX-1
    always_comb begin
        pos_next      = pos_reg;
        new_line_next = new_line_reg;
        if (in_valid) begin
            new_line_next = in_last;
            if (in_last || (pos_reg == POS_W'(LINE_MAX - 1))) begin
                pos_next = '0;
            end else begin
                pos_next = pos_reg + POS_W'(1);
            end
        end
    end

    // Position and line-boundary registers; reset opens a fresh line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_reg      <= '0;
            new_line_reg <= 1'b1;
        end else begin
            pos_reg      <= pos_next;
            new_line_reg <= new_line_next;
        end
    end

    assign out_next = run_full_next ? run_piece_next : '0;
    // A new win is out rising from 0 while nothing is latched yet
    assign new_win  = (out_next != '0) && (out_reg == '0) && !win_latched_reg;

    // Registered winner output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_reg <= '0;
        end else begin
            out_reg <= out_next;
        end
    end

    // First-win latch; clear takes priority over a simultaneous new win
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_latched_reg <= 1'b0;
            win_piece_reg   <= '0;
        end else if (clear) begin
            win_latched_reg <= 1'b0;
            win_piece_reg   <= '0;
        end else if (new_win) begin
            win_latched_reg <= 1'b1;
            win_piece_reg   <= out_next;
        end
    end

`ifdef RUN_DETECTOR_POS_EN
    // Start index of the winning run, captured alongside the latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_pos_reg <= '0;
        end else if (clear) begin
            win_pos_reg <= '0;
        end else if (new_win) begin
            win_pos_reg <= run_start_next;
        end
    end

    assign win_pos = win_pos_reg;
`else
    assign win_pos = '0;
`endif

    assign out         = out_reg;
    assign win_latched = win_latched_reg;
    assign win_piece   = win_piece_reg;

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector: directed line scenarios with literal
// expectations plus a randomized stream checked every cycle against a
// line-history model.
module tb_run_detector;
    import run_detector_pkg::*;

    localparam int PIECE_W  = 2;
    localparam int WIN_LEN  = 4;
    localparam int LINE_MAX = 7;
    localparam int POS_W    = $clog2(LINE_MAX);

    logic               clock;
    logic               reset;
    logic               clear;
    logic               in_valid;
    logic [PIECE_W-1:0] in_piece;
    logic               in_last;
    logic [PIECE_W-1:0] out;
    logic               win_latched;
    logic [PIECE_W-1:0] win_piece;
    logic [POS_W-1:0]   win_pos;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    run_detector #(
        .PIECE_W     (PIECE_W),
        .WIN_LEN     (WIN_LEN),
        .LINE_MAX    (LINE_MAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_piece    (in_piece),
        .in_last     (in_last),
        .out         (out),
        .win_latched (win_latched),
        .win_piece   (win_piece),
        .win_pos     (win_pos)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the pieces of the current line; the run is found by scanning back
    // from the newest piece.
    int               line_q[$];
    bit               m_newline = 1;
    logic [1:0]       m_out = 0;
    logic             m_wl = 0;
    logic [1:0]       m_wp = 0;
    int               m_wpos = 0;
    int               m_s;
    int               m_n;
    logic [1:0]       m_nout;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            line_q.delete();
            m_newline = 1;
            m_out     = 0;
            m_wl      = 0;
            m_wp      = 0;
            m_wpos    = 0;
        end else begin
            m_nout = m_out;
            m_s    = 0;
            if (in_valid) begin
                if (m_newline) line_q.delete();
                line_q.push_back(int'(in_piece));
                m_newline = in_last;
                m_n = line_q.size();
                m_s = m_n - 1;
                while (m_s > 0 && line_q[m_s-1] == line_q[m_n-1]) m_s--;
                if (line_q[m_n-1] != 0 && (m_n - m_s) >= WIN_LEN)
                    m_nout = 2'(line_q[m_n-1]);
                else
                    m_nout = 0;
            end
            if (clear) begin
                m_wl   = 0;
                m_wp   = 0;
                m_wpos = 0;
            end else if (!m_wl && m_out == 0 && m_nout != 0) begin
                m_wl = 1;
                m_wp = m_nout;
`ifdef RUN_DETECTOR_POS_EN
                m_wpos = m_s % LINE_MAX;
`else
                m_wpos = 0;
`endif
            end
            m_out = m_nout;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clock) begin
        if (check_en) begin
            cmp("model_out", out, m_out);
            cmp("model_win_latched", win_latched, m_wl);
            cmp("model_win_piece", win_piece, m_wp);
            cmp("model_win_pos", win_pos, m_wpos);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int p, input bit last, input bit clr);
        in_valid = 1;
        in_piece = 2'(p);
        in_last  = last;
        clear    = clr;
        @(negedge clock);
        in_valid = 0;
        in_last  = 0;
        clear    = 0;
        $display("[TB] piece=%0d last=%0d clear=%0d -> out=%0d latched=%0d wpiece=%0d wpos=%0d",
                 p, last, clr, out, win_latched, win_piece, win_pos);
    endtask

    task automatic pulse_clear();
        clear = 1;
        @(negedge clock);
        clear = 0;
    endtask

    // Reset asserted between clock edges; outputs must drop before any edge
    task automatic async_reset_pulse(input bit do_check);
        in_valid = 0;
        clear    = 0;
        in_last  = 0;
        #2 reset = 1;
        #1;
        if (do_check) begin
            cmp("async_reset_out", out, 0);
            cmp("async_reset_latched", win_latched, 0);
            cmp("async_reset_wpiece", win_piece, 0);
        end
        @(negedge clock);
        reset = 0;
    endtask

    int exp_pos33;
    logic [1:0] last_p;

    initial begin
        reset = 1; clear = 0; in_valid = 0; in_piece = 0; in_last = 0;
`ifdef RUN_DETECTOR_POS_EN
        exp_pos33 = 2;
`else
        exp_pos33 = 0;
`endif
        repeat (3) @(negedge clock);
        reset = 0;
        check_en = 1;
        cmp("reset_out", out, 0);
        cmp("reset_latched", win_latched, 0);
        cmp("reset_wpiece", win_piece, 0);
        cmp("reset_wpos", win_pos, 0);

        // 1,1,1,1 with in_last on the 4th
        send(PIECE_RED, 0, 0); send(PIECE_RED, 0, 0); send(PIECE_RED, 0, 0);
        cmp("l1_before_win_out", out, 0);
        send(PIECE_RED, 1, 0);
        cmp("l1_out", out, 1);
        cmp("l1_latched", win_latched, 1);
        cmp("l1_wpiece", win_piece, 1);
        cmp("l1_wpos", win_pos, 0);
        cmp("l1_model_out", m_out, 1);
        pulse_clear();
        cmp("clear_latched", win_latched, 0);
        cmp("clear_out_holds", out, 1);

        // 2,1,2,2,2,2
        send(PIECE_YELLOW, 0, 0); send(PIECE_RED, 0, 0); send(PIECE_YELLOW, 0, 0);
        send(PIECE_YELLOW, 0, 0); send(PIECE_YELLOW, 0, 0);
        cmp("l2_before_win_out", out, 0);
        send(PIECE_YELLOW, 1, 0);
        cmp("l2_out", out, 2);
        cmp("l2_latched", win_latched, 1);
        cmp("l2_wpos", win_pos, exp_pos33);
        cmp("l2_model_wpos", m_wpos, exp_pos33);
        pulse_clear();
        cmp("clear2_wpiece", win_piece, 0);

        // 1,1,0,1,1: empty breaks the run
        send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 0);
        cmp("l3_out", out, 0);
        cmp("l3_latched", win_latched, 0);

        // 1,1 | 1,1 across a line boundary: no win
        send(1, 0, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
        cmp("l4_out", out, 0);
        cmp("l4_latched", win_latched, 0);

        // 1x5 win, then a 2,2,2,2 win coinciding with clear
        send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
        cmp("l5_wpiece", win_piece, 1);
        send(1, 1, 0);
        send(2, 0, 0); send(2, 0, 0); send(2, 0, 0);
        cmp("l5_break_out", out, 0);
        send(2, 0, 1);
        cmp("l5_clear_win_out", out, 2);
        cmp("l5_clear_win_latched", win_latched, 0);
        send(2, 1, 0);
        cmp("l5_no_relatch", win_latched, 0);

        // Win to latch, then a partial run discarded by asynchronous reset
        send(2, 0, 0); send(2, 0, 0); send(2, 0, 0); send(2, 0, 0);
        cmp("l6_latched", win_latched, 1);
        send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
        async_reset_pulse(1);
        send(1, 0, 0);
        cmp("l6_after_reset_out", out, 0);
        send(1, 0, 0); send(1, 0, 0);
        cmp("l6_partial_out", out, 0);
        send(1, 1, 0);
        cmp("l6_out", out, 1);
        cmp("l6_wpiece", win_piece, 1);
        cmp("l6_wpos", win_pos, 0);

        // Randomized stream, biased toward repeats so wins occur
        last_p = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i == 500 || i == 1100) begin
                async_reset_pulse(0);
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) < 7) in_piece = last_p;
                else in_piece = 2'($urandom_range(0, 2));
                last_p  = in_piece;
                in_last = ($urandom_range(0, 7) == 0);
                clear   = ($urandom_range(0, 40) == 0);
                @(negedge clock);
            end
        end
        in_valid = 0; clear = 0; in_last = 0;
        @(negedge clock);
        check_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter PIECE_W, default 2: piece code width; code 0 = empty cell.
REQ-002 Parameter WIN_LEN, default 4: consecutive equal non-empty pieces that constitute a win; legal range 2..15.
REQ-003 Parameter LINE_MAX, default 7: maximum pieces per line; POS_W = $clog2(LINE_MAX).
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous clear of the latched-win outputs only.
REQ-007 in_valid  input  1  in_piece is accepted this cycle.
REQ-008 in_piece  input  PIECE_W  piece code of the next cell in the line.
REQ-009 in_last  input  1  qualifies in_piece as the final cell of the current line.
REQ-010 out  output  PIECE_W  winner code while the current run has length >= WIN_LEN, else 0.
REQ-011 win_latched  output  1  set by the first win since reset or clear.
REQ-012 win_piece  output  PIECE_W  winner code captured with win_latched.
REQ-013 win_pos  output  POS_W  line index of the first cell of the captured winning run.

Function
REQ-014 Inputs are sampled only on rising clock edges with in_valid=1; with in_valid=0, all state holds.
REQ-015 Internal state: run_piece (PIECE_W), run_len (saturating at WIN_LEN), pos (POS_W), run_start (POS_W), new_line flag.
REQ-016 Accepted piece equal to run_piece, non-empty, new_line=0: run_len += 1, saturating at WIN_LEN.
REQ-017 Accepted non-empty piece differing from run_piece, or any non-empty piece with new_line=1: run_piece=piece, run_len=1, run_start=pos.
REQ-018 Accepted empty piece (0): run_piece=0, run_len=0.
REQ-019 pos increments per accepted piece and wraps to 0 after a piece with in_last=1 or at LINE_MAX-1; new_line is set by in_last and cleared by the next accepted piece.
REQ-020 out is registered: one cycle after the accepted piece that brings run_len to WIN_LEN, out = run_piece; it holds while run_len stays saturated and returns to 0 one cycle after a breaking piece.
REQ-021 A run never spans lines: four pieces split 2+2 across an in_last boundary produce no win.
REQ-022 A win on the in_last piece is reported normally (out valid the following cycle).
REQ-023 A change of winner (e.g. runs of 1s then 2s) updates out directly from code to code without an intervening 0 cycle only if the new run saturates on that same edge; otherwise out passes through 0.
REQ-024 win_latched/win_piece set on the edge where out becomes non-zero and win_latched=0; later wins do not overwrite them.
REQ-025 clear=1 zeros win_latched, win_piece and win_pos on that edge; when coinciding with a newly reached win, clear has priority and the win is not latched.

Reset
REQ-026 reset=1 asynchronously zeros out, win_latched, win_piece, win_pos, run_piece, run_len, pos, run_start and sets new_line=1.
REQ-027 reset asserted mid-run discards the partial run; the first piece accepted after release is line index 0.

Configuration
REQ-028 Macro RUN_DETECTOR_POS_EN defined: win_pos is captured with win_latched as run_start of the winning run.
REQ-029 Macro RUN_DETECTOR_POS_EN undefined: run_start register is omitted, win_pos is constant 0, and all other behaviour is identical.

Structure
REQ-030 Package run_detector_pkg holds PIECE_EMPTY=0, PIECE_RED=1, PIECE_YELLOW=2 and the default WIN_LEN/LINE_MAX constants.
REQ-031 Run tracking (run_piece, run_len, run_start) is implemented as sub-module run_tracker; the win latch and pos counter reside in run_detector.

Verification
REQ-032 Line 1,1,1,1 (in_last on 4th) -> out=1 one cycle after the 4th piece; win_latched=1, win_piece=1, win_pos=0.
REQ-033 Line 2,1,2,2,2,2 -> out=2 after the 6th piece; win_pos=2 with RUN_DETECTOR_POS_EN defined, 0 without.
REQ-034 Line 1,1,0,1,1 -> out stays 0 throughout; win_latched=0.
REQ-035 1,1 with in_last, then 1,1 -> no win (REQ-021).
REQ-036 Line 1,1,1,1,1, then clear=1 on the same edge as a subsequent 2,2,2,2 win -> out=2; win_latched=0 after clear until the next new win.
REQ-037 reset pulsed asynchronously after 1,1,1, then 1 -> all outputs 0; run_len=1, pos=1.
